// File: rtl/mmc_dma_engine.sv
// Byte-stream DMA bridge between an MMC read-data source and a PPC DMA/Wishbone host.
// The host drains a small byte FIFO through the DATA register; the transfer length is set in LEN.
module mmc_dma_engine #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_n_i,
    input  logic       wb_cyc_i,
    input  logic       wb_stb_i,
    input  logic       wb_we_i,
    input  logic [3:0] wb_adr_i,
    input  logic [7:0] wb_dat_i,
    output logic [7:0] wb_dat_o,
    output logic       wb_ack_o,
    input  logic [7:0] src_dat_i,
    input  logic       src_vld_i,
    output logic       src_rdy_o,
    output logic       dma_req_o,
    input  logic       dma_ack_i,
    output logic       dma_eot_o,
    output logic       irq_done_o
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {IDLE, RUN, TERM} state_t;

    state_t        state_q;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q;
    logic [15:0]   len_q, rem_in_q, rem_out_q;
    logic          ack_q, start_q, abort_q, done_q, underrun_q, req_q, eot_q;
    logic [7:0]    dat_q;

    logic          wb_req, wb_wr, wb_rd, empty, full, busy, push, pop, flush;
    logic          underrun_set, done_clr, underrun_clr;
    logic [4:0]    level_ext;
    logic [7:0]    rd_mux;

    assign wb_req       = wb_cyc_i && wb_stb_i && !ack_q;
    assign wb_wr        = wb_req && wb_we_i;
    assign wb_rd        = wb_req && !wb_we_i;
    assign empty        = (level_q == '0);
    assign full         = (level_q == LW'(FIFO_DEPTH));
    assign busy         = (state_q != IDLE);
    assign src_rdy_o    = (state_q == RUN) && !full && (rem_in_q != 16'd0);
    assign push         = src_vld_i && src_rdy_o;
    assign pop          = wb_rd && (wb_adr_i == 4'd0) && !empty;
    // Start and abort reach the FSM one cycle after the CTRL write is captured.
    assign flush        = ((state_q == IDLE) && start_q && (len_q != 16'd0)) ||
                          ((state_q == RUN) && abort_q);
    assign underrun_set = (wb_rd && (wb_adr_i == 4'd0) && empty) ||
                          (dma_ack_i && (state_q == RUN) && empty);
    assign done_clr     = wb_wr && (wb_adr_i == 4'd4) && wb_dat_i[0];
    assign underrun_clr = wb_wr && (wb_adr_i == 4'd4) && wb_dat_i[1];
    assign level_ext    = 5'(level_q);

    always_comb begin
        rd_mux = 8'h00;
        case (wb_adr_i)
            4'd0:    rd_mux = empty ? 8'h00 : mem_q[rd_ptr_q];
            4'd1:    rd_mux = {7'b0, busy};
            4'd2:    rd_mux = len_q[7:0];
            4'd3:    rd_mux = len_q[15:8];
            4'd4:    rd_mux = {level_ext[3:0], 2'b00, underrun_q, done_q};
            default: rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= src_dat_i;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            len_q      <= 16'd0;
            rem_in_q   <= 16'd0;
            rem_out_q  <= 16'd0;
            ack_q      <= 1'b0;
            dat_q      <= 8'h00;
            start_q    <= 1'b0;
            abort_q    <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
            req_q      <= 1'b0;
            eot_q      <= 1'b0;
        end else begin
            ack_q   <= wb_req;
            dat_q   <= wb_rd ? rd_mux : 8'h00;
            start_q <= wb_wr && (wb_adr_i == 4'd1) && wb_dat_i[0] && !wb_dat_i[1];
            abort_q <= wb_wr && (wb_adr_i == 4'd1) && wb_dat_i[1];
            eot_q   <= 1'b0;
            req_q   <= (state_q == RUN) && !empty && (rem_out_q != 16'd0);

            if (wb_wr && (wb_adr_i == 4'd2) && !busy) len_q[7:0]  <= wb_dat_i;
            if (wb_wr && (wb_adr_i == 4'd3) && !busy) len_q[15:8] <= wb_dat_i;

            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                level_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
                case ({push, pop})
                    2'b10:   level_q <= level_q + LW'(1);
                    2'b01:   level_q <= level_q - LW'(1);
                    default: level_q <= level_q;
                endcase
            end

            if (push && (rem_in_q != 16'd0)) rem_in_q <= rem_in_q - 16'd1;
            if (pop && (state_q == RUN) && (rem_out_q != 16'd0)) rem_out_q <= rem_out_q - 16'd1;

            if (underrun_clr) underrun_q <= 1'b0;
            if (underrun_set) underrun_q <= 1'b1;
            if (done_clr)     done_q     <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (start_q) begin
                        if (len_q != 16'd0) begin
                            state_q   <= RUN;
                            rem_in_q  <= len_q;
                            rem_out_q <= len_q;
                        end else begin
                            state_q <= TERM;
                        end
                    end
                end
                RUN: begin
                    if (abort_q) begin
                        state_q   <= IDLE;
                        rem_in_q  <= 16'd0;
                        rem_out_q <= 16'd0;
                    end else if (pop && (rem_out_q == 16'd1)) begin
                        state_q <= TERM;
                    end
                end
                TERM: begin
                    // Completion outranks a same-cycle host clear of done.
                    state_q <= IDLE;
                    eot_q   <= 1'b1;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wb_ack_o   = ack_q;
    assign wb_dat_o   = dat_q;
    assign dma_req_o  = req_q;
    assign dma_eot_o  = eot_q;
    assign irq_done_o = done_q;

endmodule

// File: tb/tb_mmc_dma_engine.sv
// Directed bench for mmc_dma_engine: register access, streaming, underrun, abort and reset cases.
module tb_mmc_dma_engine;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
    logic [3:0] wb_adr = 4'd0;
    logic [7:0] wb_dat = 8'h00;
    logic [7:0] wb_dat_o;
    logic       wb_ack_o;
    logic [7:0] src_dat = 8'h00;
    logic       src_vld = 1'b0;
    logic       src_rdy_o;
    logic       dma_req_o;
    logic       dma_ack = 1'b0;
    logic       dma_eot_o;
    logic       irq_done_o;

    int n_cmp = 0;
    int n_err = 0;
    int eot_cnt = 0;
    int rdy_cnt = 0;

    mmc_dma_engine #(.FIFO_DEPTH(4)) dut (
        .wb_clk_i  (clk),
        .wb_rst_n_i(rst_n),
        .wb_cyc_i  (wb_cyc),
        .wb_stb_i  (wb_stb),
        .wb_we_i   (wb_we),
        .wb_adr_i  (wb_adr),
        .wb_dat_i  (wb_dat),
        .wb_dat_o  (wb_dat_o),
        .wb_ack_o  (wb_ack_o),
        .src_dat_i (src_dat),
        .src_vld_i (src_vld),
        .src_rdy_o (src_rdy_o),
        .dma_req_o (dma_req_o),
        .dma_ack_i (dma_ack),
        .dma_eot_o (dma_eot_o),
        .irq_done_o(irq_done_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        eot_cnt <= eot_cnt + int'(dma_eot_o);
        rdy_cnt <= rdy_cnt + int'(src_rdy_o);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wb_xfer(input logic we, input logic [3:0] adr, input logic [7:0] wd,
                           output logic [7:0] rd);
        int n;
        @(posedge clk); #1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat = wd;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!wb_ack_o && n < 8);
        rd = wb_dat_o;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        if (!wb_ack_o) chk("wb_ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic wr(input logic [3:0] adr, input logic [7:0] d);
        logic [7:0] dummy;
        wb_xfer(1'b1, adr, d, dummy);
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] adr, input logic [7:0] exp);
        logic [7:0] v;
        wb_xfer(1'b0, adr, 8'h00, v);
        chk(tag, 32'(v), 32'(exp));
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        src_dat = b; src_vld = 1'b1;
        while (!src_rdy_o && n < 16) begin
            @(posedge clk); #1;
            n++;
        end
        if (!src_rdy_o) begin
            chk("src_rdy_timeout", 32'd0, 32'd1);
        end else begin
            @(posedge clk); #1;
        end
        src_vld = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base_eot, base_rdy, cnt;
        logic r;

        // Reset state
        idle_cycles(2);
        chk("rst_ack", 32'(wb_ack_o), 32'd0);
        chk("rst_dat", 32'(wb_dat_o), 32'd0);
        chk("rst_src_rdy", 32'(src_rdy_o), 32'd0);
        chk("rst_dma_req", 32'(dma_req_o), 32'd0);
        chk("rst_eot", 32'(dma_eot_o), 32'd0);
        chk("rst_irq", 32'(irq_done_o), 32'd0);
        rst_n = 1'b1;
        rd_chk("rst_status", 4'd4, 8'h00);
        rd_chk("rst_ctrl", 4'd1, 8'h00);
        rd_chk("rst_len_lo", 4'd2, 8'h00);

        // Held strobe: ack alternates and is never high two cycles running
        @(posedge clk); #1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 4'd1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("ack_pattern", 32'(wb_ack_o), (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        wb_cyc = 1'b0; wb_stb = 1'b0;

        // Three-byte transfer
        base_eot = eot_cnt;
        wr(4'd2, 8'h03);
        wr(4'd3, 8'h00);
        wr(4'd1, 8'h01);
        rd_chk("t1_ctrl_busy", 4'd1, 8'h01);
        send_byte(8'hA1);
        send_byte(8'hB2);
        send_byte(8'hC3);
        chk("t1_src_rdy_low", 32'(src_rdy_o), 32'd0);
        chk("t1_dma_req", 32'(dma_req_o), 32'd1);
        rd_chk("t1_data0", 4'd0, 8'hA1);
        rd_chk("t1_data1", 4'd0, 8'hB2);
        rd_chk("t1_data2", 4'd0, 8'hC3);
        idle_cycles(3);
        chk("t1_eot_count", 32'(eot_cnt - base_eot), 32'd1);
        chk("t1_irq", 32'(irq_done_o), 32'd1);
        chk("t1_dma_req_off", 32'(dma_req_o), 32'd0);
        rd_chk("t1_status", 4'd4, 8'h01);
        rd_chk("t1_ctrl_idle", 4'd1, 8'h00);

        // Zero-length start: eot two cycles after the write ack
        wr(4'd4, 8'h01);
        chk("t2_irq_cleared", 32'(irq_done_o), 32'd0);
        wr(4'd2, 8'h00);
        base_rdy = rdy_cnt;
        wr(4'd1, 8'h01);
        chk("t2_eot_ack_cycle", 32'(dma_eot_o), 32'd0);
        idle_cycles(1);
        chk("t2_eot_plus1", 32'(dma_eot_o), 32'd0);
        idle_cycles(1);
        chk("t2_eot_plus2", 32'(dma_eot_o), 32'd1);
        chk("t2_irq", 32'(irq_done_o), 32'd1);
        idle_cycles(1);
        chk("t2_eot_single", 32'(dma_eot_o), 32'd0);
        chk("t2_src_rdy_never", 32'(rdy_cnt - base_rdy), 32'd0);

        // Clear of done landing on the TERM cycle loses to the set
        wr(4'd4, 8'h01);
        wr(4'd1, 8'h01);
        wr(4'd4, 8'h01);
        idle_cycles(2);
        rd_chk("t3_done_set_wins", 4'd4, 8'h01);

        // Backpressure at FIFO full, LEN = 6
        wr(4'd4, 8'h01);
        wr(4'd2, 8'h06);
        wr(4'd1, 8'h01);
        src_dat = 8'h10; src_vld = 1'b1; cnt = 0;
        for (int i = 0; i < 20; i++) begin
            r = src_rdy_o;
            @(posedge clk); #1;
            if (r) begin cnt++; src_dat = src_dat + 8'h01; end
        end
        src_vld = 1'b0;
        chk("t4_first_fill", 32'(cnt), 32'd4);
        chk("t4_src_rdy_full", 32'(src_rdy_o), 32'd0);
        rd_chk("t4_status_full", 4'd4, 8'h40);
        rd_chk("t4_data0", 4'd0, 8'h10);
        rd_chk("t4_data1", 4'd0, 8'h11);
        src_vld = 1'b1; cnt = 0;
        for (int i = 0; i < 10; i++) begin
            r = src_rdy_o;
            @(posedge clk); #1;
            if (r) begin cnt++; src_dat = src_dat + 8'h01; end
        end
        src_vld = 1'b0;
        chk("t4_refill", 32'(cnt), 32'd2);
        chk("t4_src_rdy_done", 32'(src_rdy_o), 32'd0);
        rd_chk("t4_status_full2", 4'd4, 8'h40);
        rd_chk("t4_data2", 4'd0, 8'h12);
        rd_chk("t4_data3", 4'd0, 8'h13);
        rd_chk("t4_data4", 4'd0, 8'h14);
        rd_chk("t4_data5", 4'd0, 8'h15);
        idle_cycles(3);
        rd_chk("t4_status_end", 4'd4, 8'h01);

        // Empty DATA read during RUN
        wr(4'd4, 8'h03);
        wr(4'd2, 8'h02);
        wr(4'd1, 8'h01);
        rd_chk("t5_empty_read", 4'd0, 8'h00);
        rd_chk("t5_underrun", 4'd4, 8'h02);
        send_byte(8'h77);
        send_byte(8'h88);
        rd_chk("t5_data0", 4'd0, 8'h77);
        rd_chk("t5_still_busy", 4'd1, 8'h01);
        rd_chk("t5_data1", 4'd0, 8'h88);
        idle_cycles(3);
        rd_chk("t5_status_done", 4'd4, 8'h03);
        wr(4'd4, 8'h02);
        rd_chk("t5_underrun_clr", 4'd4, 8'h01);

        // dma_ack while empty in RUN
        wr(4'd4, 8'h03);
        wr(4'd2, 8'h01);
        wr(4'd1, 8'h01);
        idle_cycles(2);
        dma_ack = 1'b1;
        @(posedge clk); #1;
        dma_ack = 1'b0;
        rd_chk("t6_ack_underrun", 4'd4, 8'h02);
        wr(4'd1, 8'h02);
        rd_chk("t6_abort_idle", 4'd1, 8'h00);
        wr(4'd4, 8'h03);

        // Abort after 2 of 5 bytes, then start+abort together
        base_eot = eot_cnt;
        wr(4'd2, 8'h05);
        wr(4'd1, 8'h01);
        send_byte(8'h55);
        send_byte(8'h66);
        wr(4'd1, 8'h02);
        idle_cycles(2);
        rd_chk("t7_ctrl", 4'd1, 8'h00);
        rd_chk("t7_status", 4'd4, 8'h00);
        chk("t7_no_eot", 32'(eot_cnt - base_eot), 32'd0);
        chk("t7_dma_req", 32'(dma_req_o), 32'd0);
        wr(4'd1, 8'h03);
        idle_cycles(2);
        rd_chk("t7_start_abort", 4'd1, 8'h00);
        chk("t7_src_rdy", 32'(src_rdy_o), 32'd0);

        // Unmapped address
        wr(4'd9, 8'hFF);
        rd_chk("t8_unmapped", 4'd9, 8'h00);
        rd_chk("t8_len_kept", 4'd2, 8'h05);

        // LEN locked while busy, then reset mid-RUN
        base_eot = eot_cnt;
        wr(4'd2, 8'h04);
        wr(4'd1, 8'h01);
        wr(4'd2, 8'h09);
        rd_chk("t9_len_locked", 4'd2, 8'h04);
        send_byte(8'h42);
        idle_cycles(1);
        chk("t9_dma_req", 32'(dma_req_o), 32'd1);
        rst_n = 1'b0;
        idle_cycles(1);
        chk("t9_ack", 32'(wb_ack_o), 32'd0);
        chk("t9_dat", 32'(wb_dat_o), 32'd0);
        chk("t9_src_rdy", 32'(src_rdy_o), 32'd0);
        chk("t9_dma_req_off", 32'(dma_req_o), 32'd0);
        chk("t9_eot", 32'(dma_eot_o), 32'd0);
        chk("t9_irq", 32'(irq_done_o), 32'd0);
        rst_n = 1'b1;
        rd_chk("t9_len_lo", 4'd2, 8'h00);
        rd_chk("t9_len_hi", 4'd3, 8'h00);
        rd_chk("t9_ctrl", 4'd1, 8'h00);
        chk("t9_no_eot", 32'(eot_cnt - base_eot), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
